// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: LSB first, one bit per clk, valid/ready load with back-to-back reload.
// Define PIS_PARITY_EN to append one even-parity bit (state PAR) after each word.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             SO,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PIS_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PAR = 2'd2} state_t;
    logic r_par, w_par_nxt;
`else
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
`endif

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sreg,  w_sreg_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_ready, w_fire;

    // Ready is decoded from state/cnt only; gating with clear keeps it low while reset is held.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
`ifdef PIS_PARITY_EN
            ST_PAR:   w_ready = 1'b1;
`else
            ST_SHIFT: w_ready = (r_cnt == LAST);
`endif
            default:  w_ready = 1'b0;
        endcase
    end

    assign load_ready = clear & w_ready;
    assign w_fire     = load_valid & load_ready;

    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
`ifdef PIS_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            ST_IDLE: ;
            ST_SHIFT: begin
                w_sreg_nxt = {1'b0, r_sreg[WIDTH-1:1]};
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
`ifdef PIS_PARITY_EN
                    w_state_nxt = ST_PAR;
`else
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef PIS_PARITY_EN
            ST_PAR: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

        // A fired handshake overrides the idle/shift defaults above, giving gap-free reload.
        if (w_fire) begin
            w_state_nxt = ST_SHIFT;
            w_sreg_nxt  = D;
            w_cnt_nxt   = '0;
`ifdef PIS_PARITY_EN
            w_par_nxt   = ^D;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
`ifdef PIS_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
`ifdef PIS_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        SO       = 1'b0;
        so_valid = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                SO       = r_sreg[0];
                so_valid = 1'b1;
            end
`ifdef PIS_PARITY_EN
            ST_PAR: begin
                SO       = r_par;
                so_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy = so_valid;
    assign done = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed tables with literal expectations plus a queue model checked every cycle.
// Honours PIS_PARITY_EN the same way as the design.
module tb_piso_serializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clear;
    logic [WIDTH-1:0] D;
    logic             load_valid;
    logic             load_ready, SO, so_valid, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .clear(clear), .D(D), .load_valid(load_valid),
        .load_ready(load_ready), .SO(SO), .so_valid(so_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a queue of the serial bits still to appear on SO, front = bit on SO this cycle.
    bit   q[$];
    logic m_done;

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            q.delete();
            m_done <= 1'b0;
        end else begin
            m_done <= (q.size() == 1);
            if (load_valid && q.size() <= 1) begin
                if (q.size() > 0) void'(q.pop_front());
                for (int k = 0; k < WIDTH; k++) q.push_back(D[k]);
`ifdef PIS_PARITY_EN
                q.push_back(^D);
`endif
            end else if (q.size() > 0) begin
                void'(q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_so",    SO,         (q.size() > 0) ? q[0] : 1'b0);
        check("mdl_sov",   so_valid,   q.size() > 0);
        check("mdl_busy",  busy,       q.size() > 0);
        check("mdl_done",  done,       m_done);
        check("mdl_ready", load_ready, clear && (q.size() <= 1));
    end

    // Table entry: {lv, d[3:0], so, so_valid, done, load_ready}; outputs are expectations for the
    // current cycle, lv/d are driven for the edge that ends it.
    logic [8:0] tbl[$];

    function automatic logic [8:0] e(input logic lv, input logic [3:0] d,
                                     input logic so, input logic sov, input logic dn, input logic rdy);
        return {lv, d, so, sov, dn, rdy};
    endfunction

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s[%0d].so",    name, i), SO,         tbl[i][3]);
            check($sformatf("%s[%0d].sov",   name, i), so_valid,   tbl[i][2]);
            check($sformatf("%s[%0d].done",  name, i), done,       tbl[i][1]);
            check($sformatf("%s[%0d].ready", name, i), load_ready, tbl[i][0]);
            load_valid = tbl[i][8];
            D          = tbl[i][7:4];
        end
        tbl.delete();
    endtask

    initial begin
        clear = 1'b0; load_valid = 1'b0; D = '0;
        #1;
        check("rst_so", SO, 0); check("rst_sov", so_valid, 0); check("rst_busy", busy, 0);
        check("rst_done", done, 0); check("rst_ready", load_ready, 0);
        repeat (2) @(negedge clk);
        #1 clear = 1'b1;

        // Single word 1011.
        tbl.push_back(e(1, 4'b1011, 0, 0, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
`ifdef PIS_PARITY_EN
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 1));
`else
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 1));
`endif
        tbl.push_back(e(0, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(e(0, 4'b0000, 0, 0, 0, 1));
        run_table("single");

        // Back-to-back 0110 then 1001 with load_valid held.
        tbl.push_back(e(1, 4'b0110, 0, 0, 0, 1));
        tbl.push_back(e(1, 4'b1001, 0, 1, 0, 0));
        tbl.push_back(e(1, 4'b1001, 1, 1, 0, 0));
        tbl.push_back(e(1, 4'b1001, 1, 1, 0, 0));
`ifdef PIS_PARITY_EN
        tbl.push_back(e(1, 4'b1001, 0, 1, 0, 0));
        tbl.push_back(e(1, 4'b1001, 0, 1, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 1, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 1));
`else
        tbl.push_back(e(1, 4'b1001, 0, 1, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 1, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 1));
`endif
        tbl.push_back(e(0, 4'b0000, 0, 0, 1, 1));
        run_table("b2b");

        // Mid-word load request is ignored until the last-slot handshake.
        tbl.push_back(e(1, 4'b0000, 0, 0, 0, 1));
        tbl.push_back(e(1, 4'b1111, 0, 1, 0, 0));
        tbl.push_back(e(1, 4'b1111, 0, 1, 0, 0));
        tbl.push_back(e(1, 4'b1111, 0, 1, 0, 0));
`ifdef PIS_PARITY_EN
        tbl.push_back(e(1, 4'b1111, 0, 1, 0, 0));
        tbl.push_back(e(1, 4'b1111, 0, 1, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 1, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 1));
`else
        tbl.push_back(e(1, 4'b1111, 0, 1, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 1, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 1));
`endif
        tbl.push_back(e(0, 4'b0000, 0, 0, 1, 1));
        run_table("ignored");

        // Abort after two bits of 1111.
        tbl.push_back(e(1, 4'b1111, 0, 0, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        run_table("pre_abort");
        clear = 1'b0;
        #1;
        check("abort_so", SO, 0); check("abort_sov", so_valid, 0); check("abort_busy", busy, 0);
        check("abort_done", done, 0); check("abort_ready", load_ready, 0);
        repeat (2) @(negedge clk);
        #1 clear = 1'b1;
        tbl.push_back(e(1, 4'b0101, 0, 0, 0, 1));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 1, 1, 0, 0));
`ifdef PIS_PARITY_EN
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 0));
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 1));
`else
        tbl.push_back(e(0, 4'b0000, 0, 1, 0, 1));
`endif
        tbl.push_back(e(0, 4'b0000, 0, 0, 1, 1));
        run_table("post_abort");

        // Free-running traffic with D changing every cycle; only the model checks here.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            load_valid = 1'($urandom_range(0, 3) != 0);
            D          = WIDTH'($urandom);
        end
        @(negedge clk);
        #1 load_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
